shared_ram_responder: RTL and testbench
=======================================

// Module: shared_ram_responder
// PURPOSE
//  Memory-side responder for the two processor cores' shared data RAM. Each core issues
//  requests (en/we/addr/din); this block arbitrates them onto one single-ported storage
//  array, then returns read data with a valid strobe. It sits between both cores and the
//  storage array. It replaces free-running dual access with a req/grant handshake.
//  After reset it clears the array, then serves requests only while start is high.
// PARAMETERS
//  DATA_W  32   data word width
//  ADDR_W  8    address width
//  DEPTH   256  number of words (= 2**ADDR_W)
// PORTS
//  clk    in   1       system clock, all logic on rising edge
//  rst    in   1       synchronous, active-high reset
//  start  in   1       run enable shared with both cores
//  en1    in   1       core1 request valid, held until gnt1
//  we1    in   1       core1 write (1) / read (0)
//  addr1  in   ADDR_W  core1 word address
//  din1   in   DATA_W  core1 write data
//  gnt1   out  1       core1 request accepted this cycle
//  vld1   out  1       dout1 holds core1 read data
//  dout1  out  DATA_W  core1 read data
//  en2/we2/addr2/din2/gnt2/vld2/dout2  same as the core1 ports, for core2
//  ready  out  1       1 = clear sweep finished, array usable
// BEHAVIOUR
//  - FSM states: CLEAR -> IDLE -> RUN.
//    - rst (any state, any cycle) forces CLEAR and clr_cnt=0.
//    - CLEAR writes 0 to mem[clr_cnt] every cycle. After writing DEPTH-1 it enters IDLE.
//    - IDLE -> RUN when start=1. RUN -> IDLE when start=0.
//  - Reset values: gnt1=gnt2=0, vld1=vld2=0, dout1=dout2=0, ready=0, rr_ptr=0.
//    ready=1 only in IDLE/RUN.
//  - Grants are issued only in RUN and are combinational from the current en*/rr_ptr.
//    At most one grant per cycle. No grants in CLEAR or IDLE; requests are simply held.
//  - Arbitration:
//    - Only one core requesting: that core is granted.
//    - Both requesting: rr_ptr=0 -> core1 wins, rr_ptr=1 -> core2 wins.
//    - After any grant, rr_ptr <= index of the loser (1 after gnt1, 0 after gnt2).
//  - Write: when gnt & we, mem[addr] <= din at that clock edge. No vld is raised.
//  - Read: when gnt & ~we, dout<n> <= mem[addr] and vld<n> <= 1 on the next cycle
//    (latency 1). vld is a one-cycle pulse. dout holds its value until the next read.
//  - Write-then-read of the same address on consecutive grants returns the new data.
//  - start falling while a read is in flight: the read still completes (vld next cycle).
//    New grants stop immediately.
//  - Reset mid-operation: any in-flight vld is suppressed and the sweep restarts at 0.
//  - Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W), so there is no wrap logic.
// TESTING
//  1. Reset, then hold start=0 for 300 cycles
//     -> ready rises exactly DEPTH=256 cycles after rst deasserts; no gnt while start=0.
//  2. start=1; core1 writes 0xDEADBEEF to 0x10, then reads 0x10
//     -> gnt1 each cycle; vld1 one cycle after the read grant; dout1=0xDEADBEEF.
//  3. After reset, both cores read addr 0x05 in the same cycle
//     -> gnt1 first (rr_ptr=0), gnt2 the next cycle; both get dout=0; rr_ptr ends at 0.
//  4. Both cores hold en continuously for 6 cycles
//     -> grants strictly alternate 1,2,1,2,1,2; never both gnt in one cycle.
//  5. Core2 read granted, then start=0 in the following cycle
//     -> vld2 still pulses once; no further grants while start=0.
//  6. Write 0x12345678 to 0xFF, pulse rst mid-run, then read 0xFF after ready
//     -> dout=0 (array cleared); vld suppressed during the sweep.

Source files
------------

// File: rtl/shared_ram_responder.sv
// rtl/shared_ram_responder.sv - two-core arbitrated responder for a single-ported shared data RAM
// Clears the array after reset, then round-robins core requests onto it while start is high.
module shared_ram_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  output logic              vld1,
  output logic [DATA_W-1:0] dout1,
  input  logic              en2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din2,
  output logic              gnt2,
  output logic              vld2,
  output logic [DATA_W-1:0] dout2,
  output logic              ready
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                vld1_q, vld2_q;
  logic [DATA_W-1:0]   dout1_q, dout2_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                rd1, rd2;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    gnt1      = 1'b0;
    gnt2      = 1'b0;
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_cnt_q;
    mem_wdata = '0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
        if (!start) begin
          state_d = IDLE;
        end else begin
          // rr_ptr names the core that wins a tie; it then points at the loser
          gnt1 = en1 & (~en2 | ~rr_ptr_q);
          gnt2 = en2 & ~gnt1;
        end
        if (gnt1) begin
          rr_ptr_d  = 1'b1;
          mem_we    = we1;
          mem_addr  = addr1;
          mem_wdata = din1;
        end else if (gnt2) begin
          rr_ptr_d  = 1'b0;
          mem_we    = we2;
          mem_addr  = addr2;
          mem_wdata = din2;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // Nothing is accepted or advertised in a reset cycle, so no access can slip past it
    if (rst) begin
      gnt1   = 1'b0;
      gnt2   = 1'b0;
      ready  = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign rd1 = gnt1 & ~we1;
  assign rd2 = gnt2 & ~we2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rr_ptr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      dout1_q <= '0;
      dout2_q <= '0;
    end else begin
      vld1_q <= rd1;
      vld2_q <= rd2;
      if (rd1) begin
        dout1_q <= mem_q[addr1];
      end
      if (rd2) begin
        dout2_q <= mem_q[addr2];
      end
    end
  end

  assign vld1  = vld1_q;
  assign vld2  = vld2_q;
  assign dout1 = dout1_q;
  assign dout2 = dout2_q;

endmodule

// File: tb/tb_shared_ram_responder.sv
// tb/tb_shared_ram_responder.sv - directed self-checking bench for shared_ram_responder
module tb_shared_ram_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst, start;
  logic              en1, we1, en2, we2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [DATA_W-1:0] din1, din2;
  logic              gnt1, gnt2, vld1, vld2, ready;
  logic [DATA_W-1:0] dout1, dout2;

  int n_checks = 0;
  int n_pass   = 0;

  shared_ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .en1(en1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .vld1(vld1), .dout1(dout1),
    .en2(en2), .we2(we2), .addr2(addr2), .din2(din2),
    .gnt2(gnt2), .vld2(vld2), .dout2(dout2),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the clear sweep to finish; returns the cycle count and whether any vld pulsed
  task automatic wait_ready(output int cycles, output bit vld_seen, output bit gnt_seen);
    cycles   = 0;
    vld_seen = 1'b0;
    gnt_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cycles++;
      if (vld1 || vld2) vld_seen = 1'b1;
      if (gnt1 || gnt2) gnt_seen = 1'b1;
      if (ready) break;
    end
  endtask

  int cyc;
  bit vseen, gseen;

  initial begin
    rst = 1'b1; start = 1'b0;
    en1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    en2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0;
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_gnt",   32'({gnt1, gnt2}), 32'd0);
    check("rst_vld",   32'({vld1, vld2}), 32'd0);
    check("rst_dout1", dout1, 32'd0);
    check("rst_dout2", dout2, 32'd0);

    // 1: sweep length, requests held with start low are never granted
    rst = 1'b0;
    en1 = 1'b1; en2 = 1'b1;
    wait_ready(cyc, vseen, gseen);
    check("sweep_cycles", 32'(cyc), 32'd256);
    check("sweep_ready",  32'(ready), 32'd1);
    for (int i = 0; i < 44; i++) begin
      tick();
      if (gnt1 || gnt2) gseen = 1'b1;
    end
    check("idle_no_gnt", 32'(gseen), 32'd0);
    check("idle_ready",  32'(ready), 32'd1);
    en1 = 1'b0; en2 = 1'b0;

    // 2: core1 write then read of 0x10
    start = 1'b1;
    tick();
    en1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; din1 = 32'hDEADBEEF;
    #2 check("t2_wr_gnt1", 32'(gnt1), 32'd1);
    check("t2_wr_gnt2", 32'(gnt2), 32'd0);
    tick();
    check("t2_wr_novld", 32'(vld1), 32'd0);
    we1 = 1'b0;
    #2 check("t2_rd_gnt1", 32'(gnt1), 32'd1);
    tick();
    en1 = 1'b0;
    check("t2_vld1",  32'(vld1), 32'd1);
    check("t2_dout1", dout1, 32'hDEADBEEF);
    tick();
    check("t2_vld1_pulse", 32'(vld1), 32'd0);
    check("t2_dout1_hold", dout1, 32'hDEADBEEF);

    // 3: after reset both cores read 0x05 together
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(cyc, vseen, gseen);
    check("t3_ready", 32'(ready), 32'd1);
    start = 1'b1;
    tick();
    en1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    en2 = 1'b1; we2 = 1'b0; addr2 = 8'h05;
    #2 check("t3_first_gnt", 32'({gnt1, gnt2}), 32'b10);
    tick();
    en1 = 1'b0;
    #2 check("t3_second_gnt", 32'({gnt1, gnt2}), 32'b01);
    check("t3_vld1",  32'(vld1), 32'd1);
    check("t3_dout1", dout1, 32'd0);
    tick();
    en2 = 1'b0;
    check("t3_vld2",  32'(vld2), 32'd1);
    check("t3_dout2", dout2, 32'd0);

    // 4: continuous contention alternates, starting with core1 (rr_ptr back at 0)
    en1 = 1'b1; en2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2 check($sformatf("t4_alt%0d", i), 32'({gnt1, gnt2}), (i % 2 == 0) ? 32'b10 : 32'b01);
      tick();
    end
    en1 = 1'b0; en2 = 1'b0;

    // 5: core2 read granted, start dropped the following cycle
    en2 = 1'b1; we2 = 1'b1; addr2 = 8'h20; din2 = 32'hA5A55A5A;
    #2 check("t5_wr_gnt2", 32'(gnt2), 32'd1);
    tick();
    we2 = 1'b0;
    #2 check("t5_rd_gnt2", 32'(gnt2), 32'd1);
    tick();
    start = 1'b0; en1 = 1'b1;
    #2 check("t5_stop_gnt", 32'({gnt1, gnt2}), 32'd0);
    check("t5_vld2",  32'(vld2), 32'd1);
    check("t5_dout2", dout2, 32'hA5A55A5A);
    tick();
    check("t5_vld2_pulse", 32'(vld2), 32'd0);
    check("t5_idle_gnt",   32'({gnt1, gnt2}), 32'd0);
    en1 = 1'b0; en2 = 1'b0;

    // 6: write 0xFF, confirm, reset mid-run with a read pending, array comes back cleared
    start = 1'b1;
    tick();
    en1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; din1 = 32'h12345678;
    #2 check("t6_wr_gnt1", 32'(gnt1), 32'd1);
    tick();
    we1 = 1'b0;
    tick();
    check("t6_pre_vld1",  32'(vld1), 32'd1);
    check("t6_pre_dout1", dout1, 32'h12345678);
    rst = 1'b1;
    #2 check("t6_rst_gnt", 32'(gnt1), 32'd0);
    tick();
    rst = 1'b0; en1 = 1'b0; start = 1'b0;
    check("t6_rst_vld",   32'(vld1), 32'd0);
    check("t6_rst_ready", 32'(ready), 32'd0);
    wait_ready(cyc, vseen, gseen);
    check("t6_sweep_cycles", 32'(cyc), 32'd256);
    check("t6_sweep_novld",  32'(vseen), 32'd0);
    start = 1'b1;
    tick();
    en1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    #2 check("t6_rd_gnt1", 32'(gnt1), 32'd1);
    tick();
    en1 = 1'b0;
    check("t6_vld1",  32'(vld1), 32'd1);
    check("t6_dout1", dout1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
